vga_timing_ctrl: RTL and testbench



---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_sync_delay.sv | 39 +++
 rtl/vga_timing_ctrl.sv | 115 +++++++++++
 tb/tb_vga_timing_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, widths and types for the VGA timing block.
package vga_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int RGB_W = 12;
    localparam int CNT_W = 10;

    localparam logic [CNT_W-1:0] H_VISIBLE = 10'd640;
    localparam logic [CNT_W-1:0] H_FP      = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC    = 10'd96;
    localparam logic [CNT_W-1:0] H_BP      = 10'd48;
    localparam logic [CNT_W-1:0] H_TOTAL   = 10'd800;

    localparam logic [CNT_W-1:0] V_VISIBLE = 10'd480;
    localparam logic [CNT_W-1:0] V_FP      = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC    = 10'd2;
    localparam logic [CNT_W-1:0] V_BP      = 10'd33;
    localparam logic [CNT_W-1:0] V_TOTAL   = 10'd525;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register that ages {hs, vs, de} by DEPTH pixel ticks to
// match the picture generator's latency.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  tick_i,
    input  sync_t d_i,
    output sync_t q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_s;
        assign unused_s = clk ^ rst ^ tick_i;
        assign q_o      = d_i;
    end else begin : g_shift
        sync_t stage_q [DEPTH];

        // Shift one stage per pixel tick; idle sync levels out of reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= SYNC_IDLE;
                end
            end else if (tick_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster generator: drives pixel coordinates to the picture
// generator and re-times its colour together with hsync/vsync for the pins.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int PIX_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_valid,
    output logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb_out,
    output logic             frame_start
);

    localparam logic [2:0]       DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = H_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] V_LAST   = V_TOTAL - 10'd1;
    localparam logic [CNT_W-1:0] HS_BEG   = H_VISIBLE + H_FP;
    localparam logic [CNT_W-1:0] HS_END   = HS_BEG + H_SYNC - 10'd1;
    localparam logic [CNT_W-1:0] VS_BEG   = V_VISIBLE + V_FP;
    localparam logic [CNT_W-1:0] VS_END   = VS_BEG + V_SYNC - 10'd1;

    logic [2:0]       div_q, div_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    rgb_t             rgb_q, rgb_d;
    logic             frame_start_q, frame_start_d;
    logic             tick_s, line_end_s, frame_end_s, valid_s;
    sync_t            raw_s, dly_s;

    assign tick_s      = (CLK_DIV == 1) ? 1'b1 : (div_q == DIV_LAST);
    assign line_end_s  = (h_cnt_q == H_LAST);
    assign frame_end_s = (v_cnt_q == V_LAST);
    assign valid_s     = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);

    assign raw_s.hs = ~in_range(h_cnt_q, HS_BEG, HS_END);
    assign raw_s.vs = ~in_range(v_cnt_q, VS_BEG, VS_END);
    assign raw_s.de = valid_s;

    vga_sync_delay #(
        .DEPTH (PIX_LAT)
    ) u_sync_delay (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick_s),
        .d_i    (raw_s),
        .q_o    (dly_s)
    );

    // Next state: divider, raster counters and the tick-loaded output stage.
    always_comb begin
        div_d         = div_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        if (tick_s) begin
            div_d   = 3'd0;
            hsync_d = dly_s.hs;
            vsync_d = dly_s.vs;
            rgb_d   = dly_s.de ? rgb_in : 12'h000;
            if (line_end_s) begin
                h_cnt_d       = 10'd0;
                v_cnt_d       = frame_end_s ? 10'd0 : (v_cnt_q + 10'd1);
                frame_start_d = frame_end_s;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            div_d = div_q + 3'd1;
        end
    end

    // State registers; reset parks the raster at (0,0) with idle sync levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= 3'd0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 12'h000;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_valid   = valid_s;
    assign pix_tick    = tick_s;
    assign pix_x       = valid_s ? h_cnt_q : {X_W{1'b0}};
    assign pix_y       = valid_s ? v_cnt_q[Y_W-1:0] : {Y_W{1'b0}};
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_out     = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: four instances cover CLK_DIV 1/4 and
// generator latencies 0/1/3, with hand-computed clock positions.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Clocks since the last reset release; after edge k it reads k.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [11:0] rgbi_a, rgbi_b, rgbi_l0, rgbi_l3;
    logic [11:0] rgbo_a, rgbo_b, rgbo_l0, rgbo_l3;
    logic [9:0]  x_a, x_b, x_l0, x_l3;
    logic [8:0]  y_a, y_b, y_l0, y_l3;
    logic        val_a, val_b, val_l0, val_l3;
    logic        tick_a, tick_b, tick_l0, tick_l3;
    logic        hs_a, hs_b, hs_l0, hs_l3;
    logic        vs_a, vs_b, vs_l0, vs_l3;
    logic        fs_a, fs_b, fs_l0, fs_l3;
    logic [9:0]  hist0, hist1, hist2;

    function automatic logic [11:0] col_rgb(input logic [9:0] x);
        return {2'b01, x};
    endfunction

    assign rgbi_a  = 12'hABC;
    assign rgbi_b  = 12'h5A5;
    assign rgbi_l0 = col_rgb(x_l0);
    assign rgbi_l3 = col_rgb(hist2);

    // Generator model with a three-tick latency for the PIX_LAT=3 instance.
    always @(posedge clk) begin
        hist0 <= x_l3;
        hist1 <= hist0;
        hist2 <= hist1;
    end

    vga_timing_ctrl #(.CLK_DIV(1), .PIX_LAT(1)) u_a (
        .clk(clk), .rst(rst), .rgb_in(rgbi_a), .pix_x(x_a), .pix_y(y_a),
        .pix_valid(val_a), .pix_tick(tick_a), .hsync(hs_a), .vsync(vs_a),
        .rgb_out(rgbo_a), .frame_start(fs_a));
    vga_timing_ctrl #(.CLK_DIV(4), .PIX_LAT(1)) u_b (
        .clk(clk), .rst(rst), .rgb_in(rgbi_b), .pix_x(x_b), .pix_y(y_b),
        .pix_valid(val_b), .pix_tick(tick_b), .hsync(hs_b), .vsync(vs_b),
        .rgb_out(rgbo_b), .frame_start(fs_b));
    vga_timing_ctrl #(.CLK_DIV(1), .PIX_LAT(0)) u_l0 (
        .clk(clk), .rst(rst), .rgb_in(rgbi_l0), .pix_x(x_l0), .pix_y(y_l0),
        .pix_valid(val_l0), .pix_tick(tick_l0), .hsync(hs_l0), .vsync(vs_l0),
        .rgb_out(rgbo_l0), .frame_start(fs_l0));
    vga_timing_ctrl #(.CLK_DIV(1), .PIX_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .rgb_in(rgbi_l3), .pix_x(x_l3), .pix_y(y_l3),
        .pix_valid(val_l3), .pix_tick(tick_l3), .hsync(hs_l3), .vsync(vs_l3),
        .rgb_out(rgbo_l3), .frame_start(fs_l3));

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target) begin
            @(negedge clk);
            guard++;
            if (guard > 90000) begin
                $display("FAIL wait_cyc timeout got=%0d want=%0d", cyc, target);
                $fatal(1, "cycle budget exceeded");
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (hs_a !== 1'b1)      begin bad++; $display("FAIL reset_hsync got=%0b want=1", hs_a); end
        total++; if (vs_a !== 1'b1)      begin bad++; $display("FAIL reset_vsync got=%0b want=1", vs_a); end
        total++; if (rgbo_a !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%0h want=0", rgbo_a); end
        total++; if (x_a !== 10'd0)      begin bad++; $display("FAIL reset_pix_x got=%0d want=0", x_a); end
        total++; if (y_a !== 9'd0)       begin bad++; $display("FAIL reset_pix_y got=%0d want=0", y_a); end
        total++; if (val_a !== 1'b1)     begin bad++; $display("FAIL reset_valid got=%0b want=1", val_a); end
        total++; if (fs_a !== 1'b0)      begin bad++; $display("FAIL reset_frame_start got=%0b want=0", fs_a); end
        total++; if (tick_a !== 1'b1)    begin bad++; $display("FAIL reset_tick_div1 got=%0b want=1", tick_a); end
        total++; if (tick_b !== 1'b0)    begin bad++; $display("FAIL reset_tick_div4 got=%0b want=0", tick_b); end
        total++; if (hs_l3 !== 1'b1)     begin bad++; $display("FAIL reset_hsync_lat3 got=%0b want=1", hs_l3); end
        rst = 1'b0;
    endtask

    task automatic test_hsync_line();
        int   fall1 = -1, fall2 = -1, low = 0, on = 0, fs_cnt = 0, vs_low = 0;
        logic prev = 1'b1;
        while (cyc < 1600) begin
            @(negedge clk);
            if (prev && !hs_a) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            prev = hs_a;
            if (!hs_a && cyc < 1000) low++;
            if (cyc <= 800 && rgbo_a == 12'hABC) on++;
            if (fs_a) fs_cnt++;
            if (!vs_a) vs_low++;
            if (cyc == 1) begin
                total++; if (rgbo_a !== 12'h000) begin bad++; $display("FAIL rgb_tick1 got=%0h want=0", rgbo_a); end
            end
            if (cyc == 2) begin
                total++; if (rgbo_a !== 12'hABC) begin bad++; $display("FAIL rgb_first got=%0h want=abc", rgbo_a); end
            end
            if (cyc == 642) begin
                total++; if (rgbo_a !== 12'h000) begin bad++; $display("FAIL rgb_hblank got=%0h want=0", rgbo_a); end
            end
            if (cyc == 5) begin
                total++; if (x_a !== 10'd5) begin bad++; $display("FAIL pix_x_5 got=%0d want=5", x_a); end
            end
            if (cyc == 800) begin
                total++; if (y_a !== 9'd1 || x_a !== 10'd0) begin
                    bad++; $display("FAIL line_wrap got=x%0d,y%0d want=x0,y1", x_a, y_a);
                end
            end
        end
        total++; if (fall1 != 658)  begin bad++; $display("FAIL hsync_first_fall got=%0d want=658", fall1); end
        total++; if (fall2 != 1458) begin bad++; $display("FAIL hsync_period got=%0d want=1458", fall2); end
        total++; if (low != 96)     begin bad++; $display("FAIL hsync_width got=%0d want=96", low); end
        total++; if (on != 640)     begin bad++; $display("FAIL rgb_active_count got=%0d want=640", on); end
        total++; if (fs_cnt != 0)   begin bad++; $display("FAIL frame_start_early got=%0d want=0", fs_cnt); end
        total++; if (vs_low != 0)   begin bad++; $display("FAIL vsync_early got=%0d want=0", vs_low); end
    endtask

    task automatic test_pix_lat();
        int f0 = -1, f3 = -1, e0 = 0, e3 = 0, n;
        logic p0 = 1'b1, p3 = 1'b1;
        logic [11:0] w;
        while (cyc < 2400) begin
            @(negedge clk);
            if (p0 && !hs_l0 && f0 < 0) f0 = cyc;
            if (p3 && !hs_l3 && f3 < 0) f3 = cyc;
            p0 = hs_l0;
            p3 = hs_l3;
            n = cyc - 1601;
            w = (n >= 0 && n < 640) ? col_rgb(10'(n)) : 12'h000;
            if (rgbo_l0 !== w) begin
                if (e0 == 0) $display("FAIL lat0_column n=%0d got=%0h want=%0h", n, rgbo_l0, w);
                e0++;
            end
            n = cyc - 1604;
            w = (n >= 0 && n < 640) ? col_rgb(10'(n)) : 12'h000;
            if (rgbo_l3 !== w) begin
                if (e3 == 0) $display("FAIL lat3_column n=%0d got=%0h want=%0h", n, rgbo_l3, w);
                e3++;
            end
        end
        total++; if (f0 != 2257) begin bad++; $display("FAIL lat0_hsync_fall got=%0d want=2257", f0); end
        total++; if (f3 != 2260) begin bad++; $display("FAIL lat3_hsync_fall got=%0d want=2260", f3); end
        total++; if (e0 != 0)    begin bad++; $display("FAIL lat0_rgb_errors got=%0d want=0", e0); end
        total++; if (e3 != 0)    begin bad++; $display("FAIL lat3_rgb_errors got=%0d want=0", e3); end
    endtask

    task automatic test_clk_div();
        int fall1 = -1, fall2 = -1, low = 0, et = 0, ex = 0;
        logic prev = 1'b1;
        logic [9:0] wx;
        while (cyc < 5900) begin
            @(negedge clk);
            if (prev && !hs_b) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            prev = hs_b;
            if (!hs_b && cyc < 3200) low++;
            if (cyc <= 2440 && tick_b !== ((cyc % 4) == 3)) et++;
            if (cyc <= 3260) begin
                if (cyc < 2560)      wx = 10'(cyc / 4);
                else if (cyc < 3200) wx = 10'd0;
                else                 wx = 10'((cyc - 3200) / 4);
                if (x_b !== wx) begin
                    if (ex == 0) $display("FAIL div4_pix_x cyc=%0d got=%0d want=%0d", cyc, x_b, wx);
                    ex++;
                end
            end
            if (cyc == 3200) begin
                total++; if (y_b !== 9'd1) begin bad++; $display("FAIL div4_pix_y got=%0d want=1", y_b); end
            end
        end
        total++; if (et != 0)       begin bad++; $display("FAIL div4_tick_errors got=%0d want=0", et); end
        total++; if (ex != 0)       begin bad++; $display("FAIL div4_pix_x_errors got=%0d want=0", ex); end
        total++; if (fall1 != 2632) begin bad++; $display("FAIL div4_hsync_fall got=%0d want=2632", fall1); end
        total++; if (fall2 != 5832) begin bad++; $display("FAIL div4_line_period got=%0d want=5832", fall2); end
        total++; if (low != 384)    begin bad++; $display("FAIL div4_hsync_width got=%0d want=384", low); end
    endtask

    task automatic test_vsync_frame();
        int c0 = 6500, on = 0, vlow = 0, vfall = -1, fs_cnt = 0, fs_at = -1;
        logic prev = 1'b1;
        wait_cyc(c0);
        force u_a.v_cnt_q = 10'd478;
        @(negedge clk);
        release u_a.v_cnt_q;
        while (cyc < c0 + 37502) begin
            if (cyc >= c0 + 2 && rgbo_a == 12'hABC) on++;
            if (prev && !vs_a && vfall < 0) vfall = cyc;
            prev = vs_a;
            if (!vs_a) vlow++;
            if (fs_a) begin fs_cnt++; fs_at = cyc; end
            if (cyc == c0 + 700) begin
                total++; if (y_a !== 9'd479 || val_a !== 1'b1) begin
                    bad++; $display("FAIL last_visible_row got=y%0d,v%0b want=y479,v1", y_a, val_a);
                end
            end
            if (cyc == c0 + 1500) begin
                total++; if (y_a !== 9'd0 || val_a !== 1'b0) begin
                    bad++; $display("FAIL vblank_decode got=y%0d,v%0b want=y0,v0", y_a, val_a);
                end
            end
            if (cyc == c0 + 37500) begin
                total++; if (x_a !== 10'd0 || y_a !== 9'd0 || val_a !== 1'b1) begin
                    bad++; $display("FAIL frame_wrap got=x%0d,y%0d want=x0,y0", x_a, y_a);
                end
            end
            @(negedge clk);
        end
        total++; if (rgbo_a !== 12'hABC) begin bad++; $display("FAIL frame_first_rgb got=%0h want=abc", rgbo_a); end
        total++; if (on != 1180)         begin bad++; $display("FAIL vblank_rgb_count got=%0d want=1180", on); end
        total++; if (vfall != c0 + 9502) begin bad++; $display("FAIL vsync_fall got=%0d want=%0d", vfall, c0 + 9502); end
        total++; if (vlow != 1600)       begin bad++; $display("FAIL vsync_width got=%0d want=1600", vlow); end
        total++; if (fs_cnt != 1)        begin bad++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt); end
        total++; if (fs_at != c0 + 37500) begin bad++; $display("FAIL frame_start_pos got=%0d want=%0d", fs_at, c0 + 37500); end
    endtask

    task automatic test_reset_mid();
        int low_early = 0, fs_cnt = 0;
        wait_cyc(44100);
        force u_a.v_cnt_q = 10'd200;
        @(negedge clk);
        release u_a.v_cnt_q;
        wait_cyc(44300);
        total++; if (x_a !== 10'd300 || y_a !== 9'd200) begin
            bad++; $display("FAIL mid_position got=x%0d,y%0d want=x300,y200", x_a, y_a);
        end
        total++; if (rgbo_a !== 12'hABC) begin bad++; $display("FAIL mid_rgb got=%0h want=abc", rgbo_a); end
        rst = 1'b1;
        #1;
        total++; if (rgbo_a !== 12'h000) begin bad++; $display("FAIL async_rgb got=%0h want=0", rgbo_a); end
        total++; if (x_a !== 10'd0 || y_a !== 9'd0) begin
            bad++; $display("FAIL async_pix got=x%0d,y%0d want=x0,y0", x_a, y_a);
        end
        total++; if (hs_a !== 1'b1 || vs_a !== 1'b1) begin
            bad++; $display("FAIL async_sync got=h%0b,v%0b want=h1,v1", hs_a, vs_a);
        end
        total++; if (tick_b !== 1'b0 || x_b !== 10'd0) begin
            bad++; $display("FAIL async_div4 got=t%0b,x%0d want=t0,x0", tick_b, x_b);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        while (cyc < 700) begin
            @(negedge clk);
            if (!hs_a && cyc < 658) low_early++;
            if (fs_a) fs_cnt++;
            if (cyc == 5) begin
                total++; if (x_a !== 10'd5 || y_a !== 9'd0) begin
                    bad++; $display("FAIL restart_pix got=x%0d,y%0d want=x5,y0", x_a, y_a);
                end
            end
            if (cyc == 658) begin
                total++; if (hs_a !== 1'b0) begin bad++; $display("FAIL restart_hsync got=%0b want=0", hs_a); end
            end
        end
        total++; if (low_early != 0) begin bad++; $display("FAIL restart_spurious_sync got=%0d want=0", low_early); end
        total++; if (fs_cnt != 0)    begin bad++; $display("FAIL restart_frame_start got=%0d want=0", fs_cnt); end
    endtask

    initial begin
        test_reset();
        test_hsync_line();
        test_pix_lat();
        test_clk_div();
        test_vsync_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
